rm_report_collector: RTL and testbench

- Consumer end of the runtime-monitor automata stages: samples the flat report vector (one bit per LTL report state across all clusters/stages) and converts each asserted bit into a timestamped report record.
- Records are queued in a FIFO and drained over a valid/ready interface toward the monitor's host-visible logic.
- Keeps the automata free-running. Report loss is detected and counted rather than back-pressuring the automata.

---
 rtl/rm_report_pkg.sv | 23 ++
 rtl/rm_report_fifo.sv | 57 +++++
 rtl/rm_report_collector.sv | 104 ++++++++++
 tb/tb_rm_report_collector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_report_pkg.sv
// Shared types and helpers for the runtime-monitor report collector.
package rm_report_pkg;

  localparam int unsigned ID_W_DEF    = 6;
  localparam int unsigned CYCLE_W_DEF = 32;
  localparam int unsigned SCAN_W      = 1 << ID_W_DEF;

  typedef struct packed {
    logic [ID_W_DEF-1:0]    id;
    logic [CYCLE_W_DEF-1:0] cycle;
  } rpt_record_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [ID_W_DEF-1:0] lowest_set(input logic [SCAN_W-1:0] v);
    logic [ID_W_DEF-1:0] idx;
    idx = '0;
    for (int i = int'(SCAN_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W_DEF'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rm_report_fifo.sv
// First-word-fall-through record FIFO; a push is accepted when full if a pop
// happens on the same edge.
module rm_report_fifo
  import rm_report_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  rpt_record_t      rec_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output rpt_record_t      head_o,
  output logic [LVL_W-1:0] level_o
);

  rpt_record_t      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;

  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= rec_i;
  end

endmodule

// File: rtl/rm_report_collector.sv
// Samples the automata report vector and serialises each set bit into a
// timestamped record; vectors that cannot be held are dropped and counted.
module rm_report_collector
  import rm_report_pkg::*;
#(
  parameter int unsigned NUM_REPORTS = 44,
  parameter int unsigned ID_W        = ID_W_DEF,
  parameter int unsigned CYCLE_W     = CYCLE_W_DEF,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DROP_W      = 16,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NUM_REPORTS-1:0] report_vec,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic [CYCLE_W-1:0]     rpt_cycle,
  output logic                   busy,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [LVL_W-1:0]       fifo_level
);

  logic [CYCLE_W-1:0]     cnt_q, cnt_d, stamp_q, stamp_d;
  logic [NUM_REPORTS-1:0] pend_q, pend_d, pend_clr;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   fifo_valid, fifo_full, pop, push_ok;
  logic                   drain, emptying, candidate;
  logic [ID_W_DEF-1:0]    low_idx;
  rpt_record_t            push_rec, head_rec;
  logic [LVL_W-1:0]       level;

  assign pop       = fifo_valid & rpt_ready;
  assign push_ok   = ~fifo_full | pop;
  assign low_idx   = lowest_set(SCAN_W'(pend_q));
  // Clearing the lowest set bit matches the index the encoder reports.
  assign pend_clr  = pend_q & (pend_q - NUM_REPORTS'(1));
  assign drain     = (|pend_q) & push_ok;
  assign emptying  = drain & ~(|pend_clr);
  assign candidate = run & (|report_vec);

  assign push_rec.id    = low_idx;
  assign push_rec.cycle = CYCLE_W_DEF'(stamp_q);

  always_comb begin
    cnt_d   = run ? cnt_q + CYCLE_W'(1) : cnt_q;
    pend_d  = drain ? pend_clr : pend_q;
    stamp_d = stamp_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (candidate) begin
      if (~(|pend_q) || emptying) begin
        pend_d  = report_vec;
        stamp_d = cnt_q;
      end else begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      stamp_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stamp_q <= stamp_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  rm_report_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (drain),
    .rec_i   (push_rec),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .head_o  (head_rec),
    .level_o (level)
  );

  assign rpt_valid  = fifo_valid;
  assign rpt_id     = fifo_valid ? ID_W'(head_rec.id) : '0;
  assign rpt_cycle  = fifo_valid ? CYCLE_W'(head_rec.cycle) : '0;
  assign busy       = |pend_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_rm_report_collector.sv
// Directed bench for rm_report_collector: queue-based reference model checked
// every cycle, plus literal expectations on the emitted record stream.
module tb_rm_report_collector;

  localparam int NR = 44;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          rpt_ready = 1'b0;
  logic [NR-1:0] report_vec = '0;
  logic          rpt_valid, busy, overflow;
  logic [5:0]    rpt_id;
  logic [31:0]   rpt_cycle;
  logic [15:0]   drop_count;
  logic [4:0]    fifo_level;

  logic          run4 = 1'b0;
  logic          ready4 = 1'b1;
  logic [NR-1:0] vec4 = '0;
  logic          valid4, busy4, ovf4;
  logic [5:0]    id4;
  logic [3:0]    cyc4;
  logic [15:0]   drop4;
  logic [4:0]    level4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rm_report_collector dut (
    .clk(clk), .reset(reset), .run(run), .report_vec(report_vec),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id),
    .rpt_cycle(rpt_cycle), .busy(busy), .overflow(overflow),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  rm_report_collector #(.CYCLE_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run4), .report_vec(vec4),
    .rpt_valid(valid4), .rpt_ready(ready4), .rpt_id(id4),
    .rpt_cycle(cyc4), .busy(busy4), .overflow(ovf4),
    .drop_count(drop4), .fifo_level(level4)
  );

  typedef struct {
    int     id;
    longint cyc;
  } mrec_t;

  // Reference model: pending vector as a list of ids, FIFO as a record queue.
  mrec_t  mq[$];
  int     mpend[$];
  longint mstamp, mcnt;
  bit     movf;
  int     mdrop;
  bit     m_pop, m_pok, m_drn, m_empt, m_was_empty;
  mrec_t  m_r;

  mrec_t  log_q[$];
  mrec_t  log4[$];
  mrec_t  l_r;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mpend.delete();
      mcnt   = 0;
      mstamp = 0;
      movf   = 1'b0;
      mdrop  = 0;
    end else begin
      m_was_empty = (mpend.size() == 0);
      m_pop  = (mq.size() > 0) && rpt_ready;
      m_pok  = (mq.size() < 16) || m_pop;
      m_drn  = !m_was_empty && m_pok;
      m_empt = m_drn && (mpend.size() == 1);
      if (m_pop) void'(mq.pop_front());
      if (m_drn) begin
        m_r.id  = mpend.pop_front();
        m_r.cyc = mstamp;
        mq.push_back(m_r);
      end
      if (run && report_vec != '0) begin
        if (m_was_empty || m_empt) begin
          for (int i = 0; i < NR; i++) if (report_vec[i]) mpend.push_back(i);
          mstamp = mcnt;
        end else begin
          movf = 1'b1;
          if (mdrop < 65535) mdrop++;
        end
      end
      if (run) mcnt = (mcnt + 1) % 64'h1_0000_0000;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid", rpt_valid, (mq.size() > 0) ? 1 : 0);
      chk("id", rpt_id, (mq.size() > 0) ? mq[0].id : 0);
      chk("cycle", rpt_cycle, (mq.size() > 0) ? mq[0].cyc : 0);
      chk("busy", busy, (mpend.size() > 0) ? 1 : 0);
      chk("overflow", overflow, movf);
      chk("drop_count", drop_count, mdrop);
      chk("fifo_level", fifo_level, mq.size());
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (rpt_valid && rpt_ready) begin
        l_r.id = rpt_id; l_r.cyc = rpt_cycle; log_q.push_back(l_r);
      end
      if (valid4 && ready4) begin
        l_r.id = id4; l_r.cyc = cyc4; log4.push_back(l_r);
      end
    end
  end

  function automatic logic [NR-1:0] b(input int i);
    logic [NR-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic step(input bit r, input logic [NR-1:0] v, input bit rdy);
    run = r; report_vec = v; rpt_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit r, input bit rdy);
    repeat (n) step(r, '0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; report_vec = '0; run4 = 1'b0; vec4 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    log4.delete();
  endtask

  task automatic chk_log(input string nm, input int idx, input int id, input longint cyc);
    if (idx < log_q.size()) begin
      chk({nm, "_id"}, log_q[idx].id, id);
      chk({nm, "_cyc"}, log_q[idx].cyc, cyc);
    end else begin
      chk({nm, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  logic [NR-1:0] v12;
  int nb;

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_valid", rpt_valid, 0);
    chk("rst_id", rpt_id, 0);
    chk("rst_cycle", rpt_cycle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_level", fifo_level, 0);

    // Single bit at stamp 3.
    idle(3, 1, 1);
    step(1, b(5), 1);
    idle(4, 1, 1);
    chk("t1_count", log_q.size(), 1);
    chk_log("t1_rec0", 0, 5, 3);
    chk("t1_ovf", overflow, 0);

    // Three bits at stamp 10.
    do_reset();
    idle(10, 1, 1);
    step(1, b(0) | b(17) | b(43), 1);
    nb = 0;
    repeat (6) begin
      if (busy) nb++;
      step(1, '0, 1);
    end
    chk("t2_busy_cycles", nb, 3);
    chk("t2_count", log_q.size(), 3);
    chk_log("t2_rec0", 0, 0, 10);
    chk_log("t2_rec1", 1, 17, 10);
    chk_log("t2_rec2", 2, 43, 10);

    // Drop while pending, then accept on the emptying edge.
    do_reset();
    idle(4, 1, 1);
    step(1, b(1) | b(2) | b(3), 1);
    step(1, b(9), 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 1);
    step(1, '0, 1);
    step(1, b(9), 1);
    idle(6, 1, 1);
    chk("t3_drop_after", drop_count, 1);
    chk("t3_count", log_q.size(), 4);
    chk_log("t3_rec0", 0, 1, 4);
    chk_log("t3_rec1", 1, 2, 4);
    chk_log("t3_rec2", 2, 3, 4);
    chk_log("t3_rec3", 3, 9, 7);

    // Backpressure: 20 vectors, 16 queued, 1 pending, 3 dropped.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, b(i), 0);
      step(1, '0, 0);
    end
    chk("t4_level", fifo_level, 16);
    chk("t4_busy", busy, 1);
    chk("t4_drop", drop_count, 3);
    idle(3, 0, 0);
    chk("t4_head_id", rpt_id, 0);
    chk("t4_head_cyc", rpt_cycle, 0);
    idle(25, 1, 1);
    chk("t4_count", log_q.size(), 17);
    for (int i = 0; i < 17; i++) chk_log("t4_rec", i, i, 2 * i);
    chk("t4_level_end", fifo_level, 0);

    // run gating.
    do_reset();
    idle(2, 1, 1);
    repeat (5) step(0, b(7), 1);
    step(1, b(8), 1);
    idle(4, 1, 1);
    chk("t5_count", log_q.size(), 1);
    chk_log("t5_rec0", 0, 8, 2);

    // Counter wrap on the 4-bit-stamp instance.
    do_reset();
    run = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run4 = 1'b1; vec4 = '0;
      @(negedge clk);
    end
    vec4 = b(1);
    @(negedge clk);
    vec4 = b(2);
    @(negedge clk);
    run4 = 1'b0; vec4 = '0;
    repeat (5) @(negedge clk);
    chk("t6_count", log4.size(), 2);
    if (log4.size() >= 2) begin
      chk("t6_rec0_id", log4[0].id, 1);
      chk("t6_rec0_cyc", log4[0].cyc, 15);
      chk("t6_rec1_id", log4[1].id, 2);
      chk("t6_rec1_cyc", log4[1].cyc, 0);
    end

    // Asynchronous reset mid-drain.
    do_reset();
    v12 = NR'(12'hFFF);
    step(1, v12, 0);
    step(1, b(40), 0);
    idle(3, 0, 0);
    chk("t7_pre_level", fifo_level, 4);
    chk("t7_pre_busy", busy, 1);
    chk("t7_pre_ovf", overflow, 1);
    #2 reset = 1'b1;
    #1;
    chk("t7_valid", rpt_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_level", fifo_level, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_drop", drop_count, 0);
    @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    step(1, b(3), 1);
    idle(3, 1, 1);
    chk("t7_count", log_q.size(), 1);
    chk_log("t7_rec0", 0, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
